// File: rtl/im_loader.sv
// im_loader: serial program loader for the instruction memory.
//
// Receives a big-endian 16-bit word count followed by count*4 program bytes
// and writes each assembled 32-bit word (big-endian) to consecutive
// instruction-memory addresses starting at BASE_ADDR. The processor core is
// held in reset for the whole load and is released only on success.
//
// Ports:
//   clk         rising-edge clock
//   rst_f       synchronous active-high reset
//   load_start  one-cycle request to start a load (ignored while busy)
//   byte_in     serial program byte
//   byte_valid  byte_in holds a valid byte
//   byte_ready  loader accepts byte_in this cycle
//   im_addr     instruction-memory write address
//   im_wdata    instruction word to write
//   im_we       instruction-memory write strobe
//   cpu_rst_f   active-low core reset (0 holds the core in reset)
//   busy        load in progress
//   done        load completed successfully
//   err         load aborted, count exceeded MAX_WORDS
//
// All outputs come straight from flops. Their next values are derived from
// the next state, so each registered output always agrees with the current
// state register.

module im_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [15:0] MAX_WORDS = 16'd1024
) (
   input  logic        clk,
   input  logic        rst_f,
   input  logic        load_start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [15:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        im_we,
   output logic        cpu_rst_f,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_HI = 3'd1,
      HDR_LO = 3'd2,
      LOAD   = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_e;

   state_e      state_q, state_d;

   logic [15:0] count_q, count_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;

   logic        byte_ready_q, byte_ready_d;
   logic [15:0] im_addr_q, im_addr_d;
   logic [31:0] im_wdata_q, im_wdata_d;
   logic        im_we_q, im_we_d;
   logic        cpu_rst_f_q, cpu_rst_f_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        xfer;
   logic        start;
   logic [15:0] hdr_count;

   // byte_ready_q is high exactly in the byte-accepting states.
   assign xfer      = byte_valid && byte_ready_q;
   assign start     = load_start &&
                      ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
   // Full count as it will be once the low header byte is captured.
   assign hdr_count = {count_q[15:8], byte_in};

   // State register
   always_ff @(posedge clk) begin
      if (rst_f) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) state_d = HDR_HI;
         end
         HDR_HI: begin
            if (xfer) state_d = HDR_LO;
         end
         HDR_LO: begin
            if (xfer) begin
               if (hdr_count == 16'd0)            state_d = DONE;
               else if (hdr_count > MAX_WORDS)    state_d = ERR;
               else                               state_d = LOAD;
            end
         end
         LOAD: begin
            if (xfer && (byte_cnt_q == 2'd3)) state_d = WRITE;
         end
         WRITE: begin
            // word_cnt_q counts words written before this one.
            if ((word_cnt_q + 16'd1) == count_q) state_d = DONE;
            else                                 state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath logic
   always_comb begin
      count_d    = count_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;

      if (start) begin
         im_addr_d  = BASE_ADDR;
         count_d    = 16'd0;
         word_cnt_d = 16'd0;
         byte_cnt_d = 2'd0;
      end

      case (state_q)
         HDR_HI: begin
            if (xfer) count_d[15:8] = byte_in;
         end
         HDR_LO: begin
            if (xfer) count_d[7:0] = byte_in;
         end
         LOAD: begin
            if (xfer) begin
               // Byte lane chosen by position: first byte lands in the MSBs.
               case (byte_cnt_q)
                  2'd0:    im_wdata_d[31:24] = byte_in;
                  2'd1:    im_wdata_d[23:16] = byte_in;
                  2'd2:    im_wdata_d[15:8]  = byte_in;
                  default: im_wdata_d[7:0]   = byte_in;
               endcase
               byte_cnt_d = byte_cnt_q + 2'd1;
            end
         end
         WRITE: begin
            // Advance only after the write cycle so addr/data stay stable
            // while im_we is high.
            im_addr_d  = im_addr_q + 16'd1;
            word_cnt_d = word_cnt_q + 16'd1;
         end
         default: ;
      endcase

      byte_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == LOAD);
      im_we_d      = (state_d == WRITE);
      busy_d       = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                     (state_d == LOAD)   || (state_d == WRITE);
      done_d       = (state_d == DONE);
      err_d        = (state_d == ERR);
      cpu_rst_f_d  = (state_d == DONE);
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (rst_f) begin
         count_q      <= 16'd0;
         word_cnt_q   <= 16'd0;
         byte_cnt_q   <= 2'd0;
         byte_ready_q <= 1'b0;
         im_addr_q    <= BASE_ADDR;
         im_wdata_q   <= 32'd0;
         im_we_q      <= 1'b0;
         cpu_rst_f_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         count_q      <= count_d;
         word_cnt_q   <= word_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         byte_ready_q <= byte_ready_d;
         im_addr_q    <= im_addr_d;
         im_wdata_q   <= im_wdata_d;
         im_we_q      <= im_we_d;
         cpu_rst_f_q  <= cpu_rst_f_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign im_addr    = im_addr_q;
   assign im_wdata   = im_wdata_q;
   assign im_we      = im_we_q;
   assign cpu_rst_f  = cpu_rst_f_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed, table-driven bench for im_loader.
//
// The normal two-word load runs from a vector table; zero count, oversize
// count, stalled stream, reset mid-word and start-while-busy are hand-written
// sequences. A monitor logs every im_we pulse so write counts, addresses and
// data can be compared against hand-computed values.

module tb_im_loader;

   logic        clk;
   logic        rst_f;
   logic        load_start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [15:0] im_addr;
   logic [31:0] im_wdata;
   logic        im_we;
   logic        cpu_rst_f;
   logic        busy;
   logic        done;
   logic        err;

   int errors;
   int checks;

   logic [15:0] wr_addr[$];
   logic [31:0] wr_data[$];

   typedef struct packed {
      logic        byte_ready;
      logic        im_we;
      logic [15:0] im_addr;
      logic [31:0] im_wdata;
      logic        cpu_rst_f;
      logic        busy;
      logic        done;
      logic        err;
   } outs_t;

   typedef struct packed {
      logic        rst;
      logic        ls;
      logic [7:0]  b;
      logic        v;
      logic        chkw;
      outs_t       exp;
   } vec_t;

   vec_t vecs[15];

   im_loader #(
      .BASE_ADDR(16'h0000),
      .MAX_WORDS(16'd4)
   ) dut (
      .clk        (clk),
      .rst_f      (rst_f),
      .load_start (load_start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .im_addr    (im_addr),
      .im_wdata   (im_wdata),
      .im_we      (im_we),
      .cpu_rst_f  (cpu_rst_f),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every write strobe, sampled away from the active edge.
   always @(negedge clk) begin
      if (im_we) begin
         wr_addr.push_back(im_addr);
         wr_data.push_back(im_wdata);
      end
   end

   function automatic outs_t so(input logic r, input logic we, input logic [15:0] a,
                                input logic [31:0] d, input logic c, input logic bz,
                                input logic dn, input logic e);
      outs_t o;
      o.byte_ready = r;
      o.im_we      = we;
      o.im_addr    = a;
      o.im_wdata   = d;
      o.cpu_rst_f  = c;
      o.busy       = bz;
      o.done       = dn;
      o.err        = e;
      return o;
   endfunction

   function automatic vec_t mkVec(input logic r, input logic ls, input logic [7:0] b,
                                  input logic v, input logic chkw, input outs_t exp);
      vec_t x;
      x.rst  = r;
      x.ls   = ls;
      x.b    = b;
      x.v    = v;
      x.chkw = chkw;
      x.exp  = exp;
      return x;
   endfunction

   // Drive one cycle of inputs, then move to 1 unit past the edge.
   task automatic applyStimulus(input logic r, input logic ls, input logic [7:0] b,
                                input logic v);
      rst_f      = r;
      load_start = ls;
      byte_in    = b;
      byte_valid = v;
      @(posedge clk);
      #1;
   endtask

   // Compare all registered outputs; im_wdata is skipped when chkw is 0.
   task automatic checkOutput(input string name, input outs_t exp_in, input logic chkw);
      outs_t act;
      outs_t exp;
      exp = exp_in;
      act = so(byte_ready, im_we, im_addr, im_wdata, cpu_rst_f, busy, done, err);
      if (!chkw) begin
         act.im_wdata = 32'd0;
         exp.im_wdata = 32'd0;
      end
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got rdy=%b we=%b addr=%h wdata=%h cpu=%b busy=%b done=%b err=%b, expected rdy=%b we=%b addr=%h wdata=%h cpu=%b busy=%b done=%b err=%b",
                  name, act.byte_ready, act.im_we, act.im_addr, act.im_wdata, act.cpu_rst_f,
                  act.busy, act.done, act.err, exp.byte_ready, exp.im_we, exp.im_addr,
                  exp.im_wdata, exp.cpu_rst_f, exp.busy, exp.done, exp.err);
      end
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(1'b0, 1'b0, b, 1'b1);
   endtask

   initial begin
      logic [7:0] stall_bytes[6];
      outs_t      load_busy;
      errors = 0;
      checks = 0;
      rst_f      = 1'b1;
      load_start = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;

      load_busy = so(1'b1, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Normal two-word load, byte_valid held high; row 0 also checks that
      // reset wins over load_start and byte_valid.
      vecs[0]  = mkVec(1, 1, 8'h00, 1, 1, so(0, 0, 16'h0000, 32'h00000000, 0, 0, 0, 0));
      vecs[1]  = mkVec(0, 1, 8'h00, 0, 1, so(1, 0, 16'h0000, 32'h00000000, 0, 1, 0, 0));
      vecs[2]  = mkVec(0, 0, 8'h00, 1, 1, so(1, 0, 16'h0000, 32'h00000000, 0, 1, 0, 0));
      vecs[3]  = mkVec(0, 0, 8'h02, 1, 1, so(1, 0, 16'h0000, 32'h00000000, 0, 1, 0, 0));
      vecs[4]  = mkVec(0, 0, 8'hDE, 1, 0, so(1, 0, 16'h0000, 32'h0, 0, 1, 0, 0));
      vecs[5]  = mkVec(0, 0, 8'hAD, 1, 0, so(1, 0, 16'h0000, 32'h0, 0, 1, 0, 0));
      vecs[6]  = mkVec(0, 0, 8'hBE, 1, 0, so(1, 0, 16'h0000, 32'h0, 0, 1, 0, 0));
      vecs[7]  = mkVec(0, 0, 8'hEF, 1, 1, so(0, 1, 16'h0000, 32'hDEADBEEF, 0, 1, 0, 0));
      vecs[8]  = mkVec(0, 0, 8'h12, 1, 0, so(1, 0, 16'h0001, 32'h0, 0, 1, 0, 0));
      vecs[9]  = mkVec(0, 0, 8'h12, 1, 0, so(1, 0, 16'h0001, 32'h0, 0, 1, 0, 0));
      vecs[10] = mkVec(0, 0, 8'h34, 1, 0, so(1, 0, 16'h0001, 32'h0, 0, 1, 0, 0));
      vecs[11] = mkVec(0, 0, 8'h56, 1, 0, so(1, 0, 16'h0001, 32'h0, 0, 1, 0, 0));
      vecs[12] = mkVec(0, 0, 8'h78, 1, 1, so(0, 1, 16'h0001, 32'h12345678, 0, 1, 0, 0));
      vecs[13] = mkVec(0, 0, 8'h99, 1, 1, so(0, 0, 16'h0002, 32'h12345678, 1, 0, 1, 0));
      vecs[14] = mkVec(0, 0, 8'hAA, 1, 1, so(0, 0, 16'h0002, 32'h12345678, 1, 0, 1, 0));

      doReset();
      $display("[TB] normal load table");
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].ls, vecs[i].b, vecs[i].v);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp, vecs[i].chkw);
      end
      checkVal("normal_wr_count", 32'(wr_addr.size()), 32'd2);

      // Zero count goes straight to DONE with no write.
      $display("[TB] zero count");
      doReset();
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      sendByte(8'h00);
      sendByte(8'h00);
      checkOutput("zero_done", so(0, 0, 16'h0000, 32'h0, 1, 0, 1, 0), 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("zero_hold", so(0, 0, 16'h0000, 32'h0, 1, 0, 1, 0), 1'b1);
      checkVal("zero_wr_count", 32'(wr_addr.size()), 32'd0);

      // Oversize count (5 > 4) aborts; later bytes are refused.
      $display("[TB] oversize count");
      doReset();
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      sendByte(8'h00);
      sendByte(8'h05);
      checkOutput("over_err", so(0, 0, 16'h0000, 32'h0, 0, 0, 0, 1), 1'b1);
      for (int i = 0; i < 3; i++) begin
         sendByte(8'h77);
         checkOutput($sformatf("over_hold%0d", i), so(0, 0, 16'h0000, 32'h0, 0, 0, 0, 1), 1'b1);
      end
      checkVal("over_wr_count", 32'(wr_addr.size()), 32'd0);
      // Restart from ERR clears err; count equal to MAX_WORDS is legal.
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput("max_restart", load_busy, 1'b0);
      sendByte(8'h00);
      sendByte(8'h04);
      checkOutput("max_load", load_busy, 1'b0);

      // Stalled stream: three idle cycles after every byte.
      $display("[TB] stalled stream");
      doReset();
      stall_bytes[0] = 8'h00;
      stall_bytes[1] = 8'h01;
      stall_bytes[2] = 8'hCA;
      stall_bytes[3] = 8'hFE;
      stall_bytes[4] = 8'hBA;
      stall_bytes[5] = 8'hBE;
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 6; i++) begin
         sendByte(stall_bytes[i]);
         if (i < 5) begin
            for (int g = 0; g < 3; g++) begin
               applyStimulus(1'b0, 1'b0, 8'h5A, 1'b0);
               checkOutput($sformatf("stall_b%0d_g%0d", i, g), load_busy, 1'b0);
            end
         end
      end
      checkOutput("stall_write", so(0, 1, 16'h0000, 32'hCAFEBABE, 0, 1, 0, 0), 1'b1);
      for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0, 8'h5A, 1'b0);
      checkOutput("stall_done", so(0, 0, 16'h0001, 32'hCAFEBABE, 1, 0, 1, 0), 1'b1);
      checkVal("stall_wr_count", 32'(wr_addr.size()), 32'd1);
      if (wr_data.size() >= 1) begin
         checkVal("stall_wr_data", wr_data[0], 32'hCAFEBABE);
         checkVal("stall_wr_addr", 32'(wr_addr[0]), 32'h0000);
      end

      // Reset after two bytes of a word abandons it.
      $display("[TB] reset mid-word");
      doReset();
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      sendByte(8'h00);
      sendByte(8'h01);
      sendByte(8'h11);
      sendByte(8'h22);
      applyStimulus(1'b1, 1'b1, 8'h33, 1'b1);
      checkOutput("midrst_state", so(0, 0, 16'h0000, 32'h0, 0, 0, 0, 0), 1'b1);
      checkVal("midrst_wr_count", 32'(wr_addr.size()), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      sendByte(8'h00);
      sendByte(8'h01);
      sendByte(8'h33);
      sendByte(8'h44);
      sendByte(8'h55);
      sendByte(8'h66);
      checkOutput("midrst_write", so(0, 1, 16'h0000, 32'h33445566, 0, 1, 0, 0), 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("midrst_done", so(0, 0, 16'h0001, 32'h33445566, 1, 0, 1, 0), 1'b1);
      checkVal("midrst_wr_count2", 32'(wr_addr.size()), 32'd1);

      // load_start during LOAD has no effect.
      $display("[TB] start while busy");
      doReset();
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      sendByte(8'h00);
      sendByte(8'h02);
      sendByte(8'hA1);
      sendByte(8'hA2);
      applyStimulus(1'b0, 1'b1, 8'hA3, 1'b1);
      checkOutput("busy_ignore", load_busy, 1'b0);
      sendByte(8'hA4);
      checkOutput("busy_write0", so(0, 1, 16'h0000, 32'hA1A2A3A4, 0, 1, 0, 0), 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      sendByte(8'hB1);
      sendByte(8'hB2);
      sendByte(8'hB3);
      sendByte(8'hB4);
      checkOutput("busy_write1", so(0, 1, 16'h0001, 32'hB1B2B3B4, 0, 1, 0, 0), 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("busy_done", so(0, 0, 16'h0002, 32'hB1B2B3B4, 1, 0, 1, 0), 1'b1);
      checkVal("busy_wr_count", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() >= 2) begin
         checkVal("busy_wr_addr1", 32'(wr_addr[1]), 32'h0001);
         checkVal("busy_wr_data1", wr_data[1], 32'hB1B2B3B4);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: instruction-memory address the first loaded word is written to.
REQ-002 Parameter MAX_WORDS, default 16'd1024: largest legal word count.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_f  input  1  synchronous, active-high reset.
REQ-005 load_start  input  1  one-cycle request to begin a program load.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 im_addr  output  16  instruction-memory write address.
REQ-010 im_wdata  output  32  instruction word to write.
REQ-011 im_we  output  1  instruction-memory write strobe.
REQ-012 cpu_rst_f  output  1  active-low reset for the processor core; 0 holds the core in reset.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  load completed successfully.
REQ-015 err  output  1  load aborted because the count exceeds MAX_WORDS.

Function
REQ-016 The loader SHALL implement the states IDLE, HDR_HI, HDR_LO, LOAD, WRITE, DONE and ERR.
REQ-017 A byte SHALL transfer only on a cycle where byte_valid=1 and byte_ready=1.
REQ-018 byte_ready SHALL be 1 in HDR_HI, HDR_LO and LOAD only, and 0 in every other state.
REQ-019 In IDLE, DONE or ERR, load_start=1 SHALL move the FSM to HDR_HI, clear done and err, set busy=1, drive cpu_rst_f=0, and set im_addr to BASE_ADDR.
REQ-020 load_start SHALL be ignored while busy=1.
REQ-021 HDR_HI SHALL capture the count[15:8] byte, and HDR_LO SHALL capture the count[7:0] byte (big-endian word count).
REQ-022 After HDR_LO, the next state SHALL be chosen as follows:
- count=0: DONE.
- count>MAX_WORDS: ERR.
- otherwise: LOAD.
REQ-023 LOAD SHALL assemble 4 bytes big-endian: the first byte goes to im_wdata[31:24] and the fourth to im_wdata[7:0].
REQ-024 A 2-bit byte counter SHALL wrap from 3 to 0 on each completed word.
REQ-025 Acceptance of the 4th byte in cycle N SHALL enter WRITE, with im_we=1 for exactly the single cycle N+1, and im_addr and im_wdata stable during that cycle.
REQ-026 In the cycle after WRITE, im_addr SHALL increment by 1 (16-bit, wrapping from 16'hFFFF to 16'h0000) and the word counter SHALL increment.
REQ-027 After WRITE, the FSM SHALL go to DONE if the word counter equals count, and otherwise return to LOAD.
REQ-028 Exactly count writes SHALL occur per load, to the addresses BASE_ADDR through BASE_ADDR+count-1.
REQ-029 In DONE, the loader SHALL drive done=1, busy=0, cpu_rst_f=1 and im_we=0, and hold these until the next load_start or reset.
REQ-030 In ERR, the loader SHALL drive err=1, busy=0 and cpu_rst_f=0, and perform no further writes.
REQ-031 Gaps in byte_valid SHALL stall the FSM in its current state with no state change and no write.
REQ-032 Bytes presented while byte_ready=0 SHALL be neither consumed nor buffered.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst_f=1 at a clock edge SHALL force the following values on the next cycle:
- state IDLE
- byte_ready=0
- im_we=0
- im_addr=BASE_ADDR
- im_wdata=0
- cpu_rst_f=0
- busy=0, done=0, err=0
- all counters at 0
REQ-035 rst_f SHALL take priority over load_start and byte_valid in the same cycle.
REQ-036 A reset mid-load SHALL abandon the partial word without writing it; words already written SHALL remain in memory.

Verification
REQ-037 Normal load: start, then bytes 00 02 | DE AD BE EF | 12 34 56 78 with byte_valid held high.
- Required: im_we pulses at addr 0000 with data DEADBEEF and at addr 0001 with data 12345678.
- Required: done=1 and cpu_rst_f=1 after the second write; byte_ready=0 on both WRITE cycles.
REQ-038 Zero count: start, then bytes 00 00.
- Required: no im_we pulse; done=1 and cpu_rst_f=1 in the cycle after HDR_LO.
REQ-039 Oversize count with MAX_WORDS=4: start, then bytes 00 05.
- Required: err=1, cpu_rst_f=0, no writes; bytes offered afterwards are not accepted.
REQ-040 Stalled stream: 1-word load with byte_valid low 3 cycles between each byte.
- Required: a single im_we pulse, data equal to the sent word, no extra writes.
REQ-041 Reset mid-word: rst_f=1 after 2 of 4 bytes.
- Required: no write; all outputs at reset values next cycle.
- Required: a fresh 1-word load then writes at BASE_ADDR.
REQ-042 Start while busy: load_start pulsed during LOAD.
- Required: ignored; the load completes with unchanged address sequence and count.
